// File: rtl/gear_pkg.sv
// Shared gear encodings, shift FSM states and the per-gear speed ceilings.
// The speed ceilings are also used by the engine model.
package gear_pkg;

  localparam int unsigned GEAR_W = 3;
  localparam int unsigned SPD_W  = 9;

  localparam logic [GEAR_W-1:0] GEAR_N = 3'd0;
  localparam logic [GEAR_W-1:0] GEAR_1 = 3'd1;
  localparam logic [GEAR_W-1:0] GEAR_2 = 3'd2;
  localparam logic [GEAR_W-1:0] GEAR_3 = 3'd3;
  localparam logic [GEAR_W-1:0] GEAR_4 = 3'd4;
  localparam logic [GEAR_W-1:0] GEAR_5 = 3'd5;
  localparam logic [GEAR_W-1:0] GEAR_6 = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLUTCH = 2'd1,
    ENGAGE = 2'd2
  } shift_state_e;

  // Highest speed (km/h) allowed in each forward gear; neutral has no ceiling entry.
  function automatic logic [SPD_W-1:0] spd_max(input logic [GEAR_W-1:0] g);
    case (g)
      GEAR_1:  spd_max = 9'd30;
      GEAR_2:  spd_max = 9'd70;
      GEAR_3:  spd_max = 9'd130;
      GEAR_4:  spd_max = 9'd200;
      GEAR_5:  spd_max = 9'd300;
      GEAR_6:  spd_max = 9'd400;
      default: spd_max = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a 1-cycle
// pulse on each debounced press (released -> pressed transition).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             w_done;

  assign w_done  = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign o_pulse = r_pulse;

  // Level only flips after the synchronised input has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_pulse <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear selector: debounced up/down requests, speed-checked shift decisions and a
// timed clutch sequence with throttle cut. Define SHIFT_QUEUE_EN to keep one request made mid-shift.
module gear_shift_ctrl
  import gear_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SHIFT_TICKS     = 3,
  parameter int unsigned MAX_GEAR        = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_10hz,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              throttle_in,
  input  logic [SPD_W-1:0]  speed_kmh,
  output logic [GEAR_W-1:0] gear,
  output logic              throttle_out,
  output logic              shifting,
  output logic              shift_denied
);

  localparam int unsigned TCNT_W = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
  localparam logic [GEAR_W-1:0] TOP_GEAR = GEAR_W'(MAX_GEAR);

  shift_state_e      r_state;
  logic [GEAR_W-1:0] r_gear;
  logic [GEAR_W-1:0] r_target;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_shifting;
  logic              r_denied;
  logic              r_throttle;

  logic              w_req_up;
  logic              w_req_dn;
  logic              w_eval_up;
  logic              w_eval_dn;
  logic              w_accept;
  logic              w_deny;
  logic [GEAR_W-1:0] w_target;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_up),
    .o_pulse (w_req_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_down),
    .o_pulse (w_req_dn)
  );

`ifdef SHIFT_QUEUE_EN
  logic r_q_up;
  logic r_q_dn;

  // Latest request seen mid-shift; consumed in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE)) begin
      r_q_up <= 1'b0;
      r_q_dn <= 1'b0;
    end else if (w_req_up && w_req_dn) begin
      r_q_up <= 1'b0;
      r_q_dn <= 1'b0;
    end else if (w_req_up) begin
      r_q_up <= 1'b1;
      r_q_dn <= 1'b0;
    end else if (w_req_dn) begin
      r_q_up <= 1'b0;
      r_q_dn <= 1'b1;
    end
  end

  assign w_eval_up = w_req_up | r_q_up;
  assign w_eval_dn = w_req_dn | r_q_dn;
`else
  assign w_eval_up = w_req_up;
  assign w_eval_dn = w_req_dn;
`endif

  // Shift legality against the current gear and the lower gear's speed ceiling.
  always_comb begin
    w_accept = 1'b0;
    w_deny   = 1'b0;
    w_target = r_gear;
    if (w_eval_up && w_eval_dn) begin
      w_deny = 1'b1;
    end else if (w_eval_up) begin
      if (r_gear == TOP_GEAR) begin
        w_deny = 1'b1;
      end else if ((r_gear == GEAR_N) && (speed_kmh > spd_max(GEAR_1))) begin
        w_deny = 1'b1;
      end else begin
        w_accept = 1'b1;
        w_target = r_gear + GEAR_W'(1);
      end
    end else if (w_eval_dn) begin
      if (r_gear == GEAR_N) begin
        w_deny = 1'b1;
      end else if (r_gear == GEAR_1) begin
        w_accept = 1'b1;
        w_target = GEAR_N;
      end else if (speed_kmh <= spd_max(r_gear - GEAR_W'(1))) begin
        w_accept = 1'b1;
        w_target = r_gear - GEAR_W'(1);
      end else begin
        w_deny = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gear     <= GEAR_N;
      r_target   <= GEAR_N;
      r_tcnt     <= '0;
      r_shifting <= 1'b0;
      r_denied   <= 1'b0;
      r_throttle <= 1'b0;
    end else begin
      r_denied <= 1'b0;
      case (r_state)
        IDLE: begin
          r_throttle <= throttle_in;
          if (w_accept) begin
            r_state    <= CLUTCH;
            r_target   <= w_target;
            r_tcnt     <= '0;
            r_shifting <= 1'b1;
            r_throttle <= 1'b0;
          end else if (w_deny) begin
            r_denied <= 1'b1;
          end
        end
        CLUTCH: begin
          r_throttle <= 1'b0;
          if (tick_10hz) begin
            if (r_tcnt == TCNT_W'(SHIFT_TICKS - 1)) begin
              r_state <= ENGAGE;
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end
        ENGAGE: begin
          r_gear     <= r_target;
          r_state    <= IDLE;
          r_shifting <= 1'b0;
          r_throttle <= throttle_in;
        end
        default: begin
          r_state    <= IDLE;
          r_shifting <= 1'b0;
          r_throttle <= 1'b0;
        end
      endcase
    end
  end

  assign gear         = r_gear;
  assign throttle_out = r_throttle;
  assign shifting     = r_shifting;
  assign shift_denied = r_denied;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed self-checking bench for gear_shift_ctrl with a short debounce window.
module tb_gear_shift_ctrl;

  localparam int unsigned DB = 8;
  localparam int unsigned ST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_10hz = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       throttle_in = 1'b0;
  logic [8:0] speed_kmh = 9'd0;
  logic [2:0] gear;
  logic       throttle_out;
  logic       shifting;
  logic       shift_denied;

  int n_checks = 0;
  int n_errors = 0;
  int deny_cnt = 0;
  int shift_cyc = 0;
  int tick_div = 0;
  int ticks = 0;
  int prev_sh = 0;
  int thr_bad = 0;
  int done = 0;
  int d0 = 0;
  int s0 = 0;
  int k = 0;

  gear_shift_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .SHIFT_TICKS     (ST),
    .MAX_GEAR        (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_10hz    (tick_10hz),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .throttle_in  (throttle_in),
    .speed_kmh    (speed_kmh),
    .gear         (gear),
    .throttle_out (throttle_out),
    .shifting     (shifting),
    .shift_denied (shift_denied)
  );

  always #5 clk = ~clk;

  // One tick every 20 clocks, changed on the falling edge.
  always @(negedge clk) begin
    tick_div  = (tick_div == 19) ? 0 : tick_div + 1;
    tick_10hz = (tick_div == 0);
  end

  always @(posedge clk) begin
    #1;
    if (shift_denied) deny_cnt++;
    if (shifting) shift_cyc++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    btn_up   = up;
    btn_down = dn;
    step(hold);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(DB + 6);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (shifting && n < 200) begin
      step();
      n++;
    end
    check("idle_timeout", int'(n < 200), 1);
  endtask

  task automatic do_shift(input logic up, input logic dn);
    press(up, dn, DB + 6);
    wait_idle();
    step(2);
  endtask

  task automatic deny_press(input string tag, input logic up, input logic dn, input int exp_gear);
    int dstart;
    dstart = deny_cnt;
    press(up, dn, DB + 6);
    step(2);
    check({tag, "_deny"}, deny_cnt - dstart, 1);
    check({tag, "_gear"}, int'(gear), exp_gear);
  endtask

  initial begin
    throttle_in = 1'b1;
    rst = 1'b1;
    step(3);
    check("rst_gear", int'(gear), 0);
    check("rst_thr", int'(throttle_out), 0);
    check("rst_shift", int'(shifting), 0);
    check("rst_deny", int'(shift_denied), 0);
    rst = 1'b0;
    step(2);
    check("thr_pass", int'(throttle_out), 1);

    // First upshift with exact engage timing and throttle cut.
    btn_up = 1'b1;
    for (int i = 0; i < 300 && done == 0; i++) begin
      step();
      if (i == int'(DB) + 6) btn_up = 1'b0;
      if (shifting && throttle_out) thr_bad = 1;
      if (prev_sh != 0 && tick_10hz) ticks++;
      if (ticks == int'(ST)) begin
        check("t1_engage_gear", int'(gear), 0);
        check("t1_engage_shift", int'(shifting), 1);
        step();
        check("t1_gear", int'(gear), 1);
        check("t1_done", int'(shifting), 0);
        done = 1;
      end
      prev_sh = int'(shifting);
    end
    btn_up = 1'b0;
    check("t1_timeout", done, 1);
    check("t1_thr_cut", thr_bad, 0);
    step(DB + 6);
    check("t1_thr_back", int'(throttle_out), 1);

    speed_kmh = 9'd0;
    do_shift(1'b1, 1'b0);
    do_shift(1'b1, 1'b0);
    check("up_to_3", int'(gear), 3);

    speed_kmh = 9'd100;
    deny_press("dn_fast", 1'b0, 1'b1, 3);

    speed_kmh = 9'd60;
    do_shift(1'b0, 1'b1);
    check("dn_3_2", int'(gear), 2);

    speed_kmh = 9'd31;
    deny_press("dn_2_31", 1'b0, 1'b1, 2);
    speed_kmh = 9'd30;
    do_shift(1'b0, 1'b1);
    check("dn_2_30", int'(gear), 1);
    do_shift(1'b0, 1'b1);
    check("dn_1_0", int'(gear), 0);
    deny_press("dn_at_n", 1'b0, 1'b1, 0);

    speed_kmh = 9'd31;
    deny_press("up_n_31", 1'b1, 1'b0, 0);
    speed_kmh = 9'd30;
    do_shift(1'b1, 1'b0);
    check("up_n_30", int'(gear), 1);

    speed_kmh = 9'd0;
    repeat (5) do_shift(1'b1, 1'b0);
    check("up_to_6", int'(gear), 6);
    deny_press("up_at_6", 1'b1, 1'b0, 6);
    deny_press("both", 1'b1, 1'b1, 6);

    // A press one cycle short of the debounce window is ignored.
    d0 = deny_cnt;
    s0 = shift_cyc;
    btn_down = 1'b1;
    step(DB - 1);
    btn_down = 1'b0;
    step(DB + 6);
    check("bounce_shift", shift_cyc - s0, 0);
    check("bounce_deny", deny_cnt - d0, 0);
    check("bounce_gear", int'(gear), 6);

    // Reset in the middle of a clutch sequence.
    btn_down = 1'b1;
    k = 0;
    while (!shifting && k < 60) begin
      step();
      k++;
    end
    check("rst_mid_start", int'(shifting), 1);
    step(2);
    rst = 1'b1;
    step();
    check("rst_mid_gear", int'(gear), 0);
    check("rst_mid_shift", int'(shifting), 0);
    check("rst_mid_thr", int'(throttle_out), 0);
    rst = 1'b0;
    btn_down = 1'b0;
    step(DB + 6);
    check("rst_mid_hold", int'(gear), 0);

    // Request arriving during a 1->2 shift.
    do_shift(1'b1, 1'b0);
    check("q_setup", int'(gear), 1);
    btn_up = 1'b1;
    step(DB + 6);
    btn_up = 1'b0;
    step(DB + 6);
    check("q_in_shift", int'(shifting), 1);
    d0 = deny_cnt;
    btn_up = 1'b1;
    step(DB + 6);
    btn_up = 1'b0;
    step(150);
`ifdef SHIFT_QUEUE_EN
    check("q_gear", int'(gear), 3);
`else
    check("drop_gear", int'(gear), 2);
`endif
    check("q_no_deny", deny_cnt - d0, 0);
    check("q_idle", int'(shifting), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
